// File: rtl/encode8_arb.sv
// encode8_arb -- 8-to-3 request encoder with a registered grant handshake.
//
// Purpose:
//   Collects single-cycle request pulses into a pending vector and presents
//   one of them at a time as a binary index (plus its one-hot form) to a
//   consumer. The block is the inverse of a 3-to-8 write-select decode.
//
// Arbitration policy:
//   Default build : fixed priority, lowest set index wins.
//   ROUND_ROBIN_EN: a 3-bit pointer is kept. The search starts at the pointer
//                   and ascends, wrapping from 7 to 0. After an accepted grant
//                   of index k the pointer moves to (k+1) mod 8.
//
// Handshake (valid/ready):
//   out_valid is the "valid" side and out_ack is the consumer's "ready". A
//   grant transfers on a rising edge where out_valid=1 and out_ack=1. Once
//   out_valid is high, out_idx/out_onehot stay stable until that transfer.
//   out_ack while out_valid=0 has no effect.
//
// Ports:
//   clk        in   1  clock, rising-edge active
//   rst_n      in   1  asynchronous active-low reset
//   req        in   8  request pulses; bit k sets pending bit k
//   enable     in   1  allows a new grant to load
//   out_ack    in   1  consumer accepts the current grant
//   out_valid  out  1  grant presented (registered)
//   out_idx    out  3  index of the granted request (registered)
//   out_onehot out  8  one-hot of out_idx while out_valid=1, else 0 (registered)
//   pending    out  8  pending-request vector (registered)

module encode8_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       enable,
  input  logic       out_ack,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic [7:0] out_onehot,
  output logic [7:0] pending
);

  logic [7:0] pending_q, pending_d;
  logic       valid_q,   valid_d;
  logic [2:0] idx_q,     idx_d;
  logic [7:0] onehot_q,  onehot_d;

  logic       accept;
  logic       load;
  logic [7:0] clr;
  logic [7:0] cand;
  logic [2:0] sel_idx;
  logic       sel_found;

  // ---------------------------------------------------------------------
  // Handshake and pending update
  // ---------------------------------------------------------------------
  always_comb begin
    accept    = valid_q & out_ack;
    clr       = accept ? onehot_q : 8'h00;
    // Candidates exclude the bit being acked this edge, so it cannot be
    // granted again on the same edge.
    cand      = pending_q & ~clr;
    // A fresh request on the acked bit wins over the clear.
    pending_d = cand | req;
    load      = (~valid_q | out_ack) & enable;
  end

`ifdef ROUND_ROBIN_EN
  // ---------------------------------------------------------------------
  // Round-robin selection starting at ptr_q
  // ---------------------------------------------------------------------
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] probe;

  always_comb begin
    sel_idx   = 3'd0;
    sel_found = 1'b0;
    probe     = 3'd0;
    // Walk from the farthest offset toward the pointer so that the last hit
    // written is the first one in search order. The 3-bit add wraps 7 -> 0.
    for (int i = 7; i >= 0; i--) begin
      probe = ptr_q + 3'(i);
      if (cand[probe]) begin
        sel_idx   = probe;
        sel_found = 1'b1;
      end
    end
  end

  // Pointer only moves on an accepted grant.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = idx_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 3'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // ---------------------------------------------------------------------
  // Fixed priority selection: lowest set index
  // ---------------------------------------------------------------------
  always_comb begin
    sel_idx   = 3'd0;
    sel_found = 1'b0;
    // Descending walk: the last hit written is the lowest index.
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) begin
        sel_idx   = 3'(i);
        sel_found = 1'b1;
      end
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Grant register next state
  // ---------------------------------------------------------------------
  always_comb begin
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (load) begin
      valid_d = sel_found;
      if (sel_found) begin
        idx_d    = sel_idx;
        onehot_d = 8'h01 << sel_idx;
      end else begin
        // Nothing to grant: drop the one-hot, keep the last index.
        onehot_d = 8'h00;
      end
    end else if (accept) begin
      // Acked while enable=0: the grant retires, index is left as is.
      valid_d  = 1'b0;
      onehot_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 8'h00;
      valid_q   <= 1'b0;
      idx_q     <= 3'd0;
      onehot_q  <= 8'h00;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      idx_q     <= idx_d;
      onehot_q  <= onehot_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_encode8_arb.sv
// Testbench for encode8_arb: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the request set and
// the single outstanding grant.

module tb_encode8_arb;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       enable;
  logic       out_ack;
  logic       out_valid;
  logic [2:0] out_idx;
  logic [7:0] out_onehot;
  logic [7:0] pending;

  int n_tests;
  int n_fail;

  // Behavioural model state
  bit m_pend [8];
  bit m_valid;
  int m_idx;
  int m_ptr;

  encode8_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .enable     (enable),
    .out_ack    (out_ack),
    .out_valid  (out_valid),
    .out_idx    (out_idx),
    .out_onehot (out_onehot),
    .pending    (pending)
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------
  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
  endtask

  function automatic logic [7:0] model_pend_vec();
    logic [7:0] v;
    v = 8'h00;
    for (int k = 0; k < 8; k++) if (m_pend[k]) v[k] = 1'b1;
    return v;
  endfunction

  // Returns the index chosen from the candidate set, or -1 if empty.
  function automatic int model_pick(input bit c [8], input int ptr);
`ifdef ROUND_ROBIN_EN
    for (int n = 0; n < 8; n++) begin
      if (c[(ptr + n) % 8]) return (ptr + n) % 8;
    end
`else
    for (int n = 0; n < 8; n++) begin
      if (c[n]) return n;
    end
`endif
    return -1;
  endfunction

  task automatic model_edge(input logic [7:0] r, input logic en, input logic ak);
    bit cand [8];
    bit accepted;
    int choice;
    accepted = m_valid && ak;
    for (int k = 0; k < 8; k++) cand[k] = m_pend[k];
    if (accepted) cand[m_idx] = 1'b0;
    choice = model_pick(cand, m_ptr);
    for (int k = 0; k < 8; k++) m_pend[k] = cand[k] | r[k];
    if (accepted) m_ptr = (m_idx + 1) % 8;
    if ((!m_valid || ak) && en) begin
      m_valid = (choice >= 0);
      if (choice >= 0) m_idx = choice;
    end else if (accepted) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [7:0] exp_oh;
    exp_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
    chk({tag, "_pending"}, pending, model_pend_vec());
    chk({tag, "_valid"}, {7'h00, out_valid}, {7'h00, m_valid});
    chk({tag, "_onehot"}, out_onehot, exp_oh);
    if (m_valid) chk({tag, "_idx"}, {5'h00, out_idx}, 8'(m_idx));
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks (called on a falling edge, return on the next one)
  // ---------------------------------------------------------------------
  task automatic step(input string tag, input logic [7:0] r, input logic en, input logic ak);
    req     = r;
    enable  = en;
    out_ack = ak;
    @(posedge clk);
    model_edge(r, en, ak);
    @(negedge clk);
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 8'h00;
    enable  = 1'b0;
    out_ack = 1'b0;
    model_reset();
    #1;
    chk("rst_pending", pending, 8'h00);
    chk("rst_valid", {7'h00, out_valid}, 8'h00);
    chk("rst_idx", {5'h00, out_idx}, 8'h00);
    chk("rst_onehot", out_onehot, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    logic [7:0] r;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    req     = 8'h00;
    enable  = 1'b0;
    out_ack = 1'b0;
    @(negedge clk);
    do_reset();

    // Basic latency and ordering
    step("s1", 8'h24, 1'b1, 1'b0);
    chk("s1_pend_const", pending, 8'h24);
    chk("s1_valid_const", {7'h00, out_valid}, 8'h00);
    step("s2", 8'h00, 1'b1, 1'b0);
    chk("s2_idx_const", {5'h00, out_idx}, 8'h02);
    chk("s2_onehot_const", out_onehot, 8'h04);
    step("s3_hold", 8'h00, 1'b1, 1'b0);
    chk("s3_onehot_const", out_onehot, 8'h04);
    step("s4_ack", 8'h00, 1'b1, 1'b1);
    chk("s4_idx_const", {5'h00, out_idx}, 8'h05);
    chk("s4_onehot_const", out_onehot, 8'h20);
    step("s5_ack", 8'h00, 1'b1, 1'b1);
    chk("s5_pend_const", pending, 8'h00);
    chk("s5_valid_const", {7'h00, out_valid}, 8'h00);

    // Request beats clear on the acked bit
    step("r1", 8'h08, 1'b1, 1'b0);
    step("r2", 8'h00, 1'b1, 1'b0);
    chk("r2_idx_const", {5'h00, out_idx}, 8'h03);
    step("r3", 8'h08, 1'b1, 1'b1);
    chk("r3_pend_const", pending, 8'h08);
    chk("r3_valid_const", {7'h00, out_valid}, 8'h00);
    step("r4", 8'h00, 1'b1, 1'b0);
    chk("r4_valid_const", {7'h00, out_valid}, 8'h01);
    chk("r4_idx_const", {5'h00, out_idx}, 8'h03);
    step("r5", 8'h00, 1'b1, 1'b1);

    // Enable gating
    step("e1", 8'hFF, 1'b0, 1'b0);
    step("e2", 8'h00, 1'b0, 1'b0);
    chk("e2_valid_const", {7'h00, out_valid}, 8'h00);
    step("e3", 8'h00, 1'b1, 1'b0);
`ifndef ROUND_ROBIN_EN
    chk("e3_idx_const", {5'h00, out_idx}, 8'h00);
`endif
    // Hold while not acked, whatever enable does
    step("h1", 8'h00, 1'b0, 1'b0);
    step("h2", 8'h00, 1'b1, 1'b0);
    // Ack with enable low retires the grant, index stays
    r = 8'(m_idx);
    step("k1", 8'h00, 1'b0, 1'b1);
    chk("k1_valid_const", {7'h00, out_valid}, 8'h00);
    chk("k1_idx_hold", {5'h00, out_idx}, r);
    // Back-to-back drain: one grant per cycle
    for (int n = 0; n < 9; n++) step("drain", 8'h00, 1'b1, 1'b1);

    // Alternating 0 / 7 with requests held
    do_reset();
    step("a0", 8'h81, 1'b1, 1'b1);
    step("a1", 8'h81, 1'b1, 1'b1);
    chk("a1_idx_const", {5'h00, out_idx}, 8'h00);
    step("a2", 8'h81, 1'b1, 1'b1);
    chk("a2_idx_const", {5'h00, out_idx}, 8'h07);
    step("a3", 8'h81, 1'b1, 1'b1);
    chk("a3_idx_const", {5'h00, out_idx}, 8'h00);
    step("a4", 8'h00, 1'b1, 1'b1);
    chk("a4_idx_const", {5'h00, out_idx}, 8'h07);
    step("a5", 8'h00, 1'b1, 1'b1);

    // Wrap from 7: accept index 6, then 0 must win over 1
    do_reset();
    step("w1", 8'h40, 1'b1, 1'b0);
    step("w2", 8'h00, 1'b1, 1'b0);
    step("w3", 8'h03, 1'b1, 1'b1);
    step("w4", 8'h00, 1'b1, 1'b0);
    chk("w4_idx_const", {5'h00, out_idx}, 8'h00);

    // Asynchronous reset in the middle of a cycle with a grant up
    step("m1", 8'h10, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_valid", {7'h00, out_valid}, 8'h00);
    chk("ar_onehot", out_onehot, 8'h00);
    chk("ar_idx", {5'h00, out_idx}, 8'h00);
    chk("ar_pending", pending, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      step("rnd", r, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encode8_arb.md
ENCODE8_ARB -- requirements
Module: encode8_arb

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: req  input  8  request pulses; bit k=1 on a rising edge sets pending bit k.
REQ-004: enable  input  1  grant enable; 0 blocks new grants from loading.
REQ-005: out_ack  input  1  consumer accepts the current grant.
REQ-006: out_valid  output  1  registered; a grant is presented.
REQ-007: out_idx  output  3  registered; binary index of granted request.
REQ-008: out_onehot  output  8  registered; one-hot of out_idx when out_valid=1, 8'h00 otherwise.
REQ-009: pending  output  8  registered pending-request vector.

Function
REQ-010: The block SHALL encode 8 request lines into a 3-bit index, the inverse of the register-file 3-to-8 write-select decode.
REQ-011: Define clr = out_onehot when (out_valid & out_ack), else 8'h00; ack with out_valid=0 SHALL be ignored.
REQ-012: pending SHALL update each edge as (pending & ~clr) | req; req SHALL win over clr on the same bit.
REQ-013: Selection SHALL operate on cand = pending & ~clr, so an acked bit is never re-granted on the ack edge.
REQ-014: Fixed priority (macro absent): the lowest set index of cand SHALL be selected.
REQ-015: Load condition: (out_valid=0 or out_ack=1) and enable=1; on load, out_valid = (cand != 0) and out_idx/out_onehot = the selection.
REQ-016: While out_valid=1 and out_ack=0, out_valid, out_idx and out_onehot SHALL hold stable regardless of req or enable.
REQ-017: If out_ack=1 and enable=0 on the same edge, out_valid SHALL drop to 0 and out_onehot to 8'h00; out_idx holds its value.
REQ-018: Latency: a req bit sampled at edge E SHALL appear in pending after E and can drive out_valid no earlier than after edge E+1.
REQ-019: Back-to-back throughput: with out_ack held 1 and multiple bits pending, one grant per cycle SHALL be issued.
REQ-020: A req bit already pending SHALL have no additional effect; there is no request counting.

Reset
REQ-021: rst_n=0 SHALL immediately clear pending=8'h00, out_valid=0, out_idx=3'b000, out_onehot=8'h00, and the priority pointer=0.
REQ-022: The first req sampled SHALL be at the first rising edge with rst_n=1; a reset mid-handshake SHALL discard the grant and all pending requests.

Configuration
REQ-023: Macro ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-024: With ROUND_ROBIN_EN defined, a 3-bit pointer SHALL be kept, and the search of cand SHALL start at the pointer and ascend with wrap from 7 to 0.
REQ-025: With ROUND_ROBIN_EN defined, after an accepted grant of index k, the pointer SHALL become (k+1) mod 8, so k=7 gives 0; the pointer SHALL NOT change otherwise.
REQ-026: Without ROUND_ROBIN_EN, no pointer register SHALL exist and REQ-014 applies.

Verification
REQ-027: Reset, then req=8'h24 for one cycle with enable=1 and out_ack=0 -> pending=8'h24 after edge 1; after edge 2, out_valid=1, out_idx=2, out_onehot=8'h04, held while ack=0.
REQ-028: From REQ-027, pulse out_ack=1 -> out_idx=5 and out_onehot=8'h20 on the next edge, then pending=8'h00; with ack held 1, out_valid=0 after the following edge.
REQ-029: While granting idx 3 (out_valid=1), drive out_ack=1 and req=8'h08 on the same edge -> pending bit 3 remains 1; out_valid=0 after that edge; idx 3 is re-granted on the next edge.
REQ-030: Set enable=0 with pending=8'hFF and out_valid=0 -> out_valid stays 0; raise enable -> out_idx=0 (fixed) after one edge.
REQ-031: ROUND_ROBIN_EN, pending=8'h81, ack held 1 -> grant order is 0, 7, 0, 7; with pointer=7 and pending=8'h03, the next grant is 0.
REQ-032: Assert rst_n=0 asynchronously mid-cycle while out_valid=1 -> all outputs read 0 before the next clock edge.
